// File: rtl/fp_single_pkg.sv
// Shared definitions for the single-precision arithmetic blocks (divider, multiplier).
package fp_single_pkg;

   // Top-level sequencing states shared by the single-precision units.
   typedef enum logic [3:0] {
      GET_A,
      GET_B,
      UNPACK,
      SPECIAL_CASES,
      NORMALISE_A,
      NORMALISE_B,
      DIVIDE_0,
      DIVIDE_1,
      DIVIDE_2,
      DIVIDE_3,
      NORMALISE_1,
      NORMALISE_2,
      ROUND,
      PACK,
      PUT_Z
   } fp_state_t;

   // Phases of the iterative mantissa divider.
   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_SHIFT,
      DIV_SUB
   } div_phase_t;

   // Exponents are carried unbiased in a 10-bit signed field.
   localparam logic signed [9:0] BIAS    = 10'sd127;
   localparam logic signed [9:0] EXP_MIN = -10'sd126;
   localparam logic signed [9:0] EXP_MAX = 10'sd127;

   localparam logic [31:0] QNAN    = 32'hFFC00000;
   localparam logic [31:0] POS_INF = 32'h7F800000;

   // Infinity carrying the requested sign.
   function automatic logic [31:0] signed_inf(input logic s);
      return POS_INF | {s, 31'd0};
   endfunction

endpackage

// File: rtl/fp_single_divider_mant.sv
// Restoring mantissa divider: one quotient bit per shift/subtract pair, 50 iterations.
// The 51-bit dividend is num_m<<27; only its top 50 bits are ever brought down, so the
// quotient needs just its low 27 bits (a normalised ratio lies in (0.5, 2)).
module fp_mant_divider
   import fp_single_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [23:0] num_m,
   input  logic [23:0] den_m,
   output logic        done,
   output logic [26:0] quotient,
   output logic [24:0] remainder
);

   localparam logic [5:0] LAST_ITER = 6'd49;

   div_phase_t  phase_q, phase_d;
   logic [5:0]  count_q, count_d;
   logic [50:0] dividend_q, dividend_d;
   logic [23:0] divisor_q, divisor_d;
   logic [26:0] quot_q, quot_d;
   logic [24:0] rem_q, rem_d;
   logic        last_iter;

   assign last_iter = (count_q == LAST_ITER);
   // done marks the cycle whose edge completes the final subtract step.
   assign done      = (phase_q == DIV_SUB) && last_iter;
   assign quotient  = quot_q;
   assign remainder = rem_q;

   // Next-state: load on start, then alternate shift and conditional subtract.
   always_comb begin
      phase_d    = phase_q;
      count_d    = count_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      if (start) begin
         dividend_d = {num_m, 27'd0};
         divisor_d  = den_m;
         quot_d     = '0;
         rem_d      = '0;
         count_d    = '0;
         phase_d    = DIV_SHIFT;
      end else begin
         case (phase_q)
            DIV_SHIFT: begin
               rem_d      = {rem_q[23:0], dividend_q[50]};
               dividend_d = {dividend_q[49:0], 1'b0};
               quot_d     = {quot_q[25:0], 1'b0};
               phase_d    = DIV_SUB;
            end
            DIV_SUB: begin
               if (rem_q >= {1'b0, divisor_q}) begin
                  quot_d[0] = 1'b1;
                  rem_d     = rem_q - {1'b0, divisor_q};
               end
               if (last_iter) begin
                  phase_d = DIV_IDLE;
               end else begin
                  count_d = count_q + 6'd1;
                  phase_d = DIV_SHIFT;
               end
            end
            default: ;
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q    <= DIV_IDLE;
         count_q    <= '0;
         dividend_q <= '0;
         divisor_q  <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
      end else begin
         phase_q    <= phase_d;
         count_q    <= count_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
      end
   end

endmodule

// File: rtl/fp_single_divider.sv
// IEEE-754 single-precision divider, z = a / b, round to nearest even.
// Handshake: each input word is taken on an edge where its _stb is high while the
// unit waits for it, and the matching _ack pulses high for the cycle after. The
// result is presented with output_z_stb high and held until an edge where
// output_z_stb and output_z_ack are both high; output_z keeps its value afterwards.
module fp_single_divider #(
   parameter logic [31:0] QNAN = fp_single_pkg::QNAN
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             input_a,
   input  logic                    input_a_stb,
   output logic                    input_a_ack,
   input  logic [31:0]             input_b,
   input  logic                    input_b_stb,
   output logic                    input_b_ack,
   output logic [31:0]             output_z,
   output logic                    output_z_stb,
   input  logic                    output_z_ack,
   output fp_single_pkg::fp_state_t dbg_state
);

   import fp_single_pkg::*;

   localparam logic signed [9:0] E_SPECIAL = EXP_MAX + 10'sd1;
   localparam logic signed [9:0] E_DENORM  = EXP_MIN - 10'sd1;

   fp_state_t         state_q, state_d;
   logic [31:0]       a_q, a_d, b_q, b_d, z_q, z_d;
   logic [23:0]       a_m_q, a_m_d, b_m_q, b_m_d, z_m_q, z_m_d;
   logic signed [9:0] a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
   logic              a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
   logic              guard_q, guard_d, round_q, round_d, sticky_q, sticky_d;
   logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
   logic              z_stb_q, z_stb_d;
   logic [31:0]       out_z_q, out_z_d;

   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_ab;
   logic              div_start, div_done;
   logic [26:0]       div_quot;
   logic [24:0]       div_rem;

   assign a_nan   = (a_e_q == E_SPECIAL) && (a_m_q != 24'd0);
   assign b_nan   = (b_e_q == E_SPECIAL) && (b_m_q != 24'd0);
   assign a_inf   = (a_e_q == E_SPECIAL) && (a_m_q == 24'd0);
   assign b_inf   = (b_e_q == E_SPECIAL) && (b_m_q == 24'd0);
   assign a_zero  = (a_e_q == E_DENORM) && (a_m_q == 24'd0);
   assign b_zero  = (b_e_q == E_DENORM) && (b_m_q == 24'd0);
   assign sign_ab = a_s_q ^ b_s_q;

   assign div_start = (state_q == DIVIDE_0);

   fp_mant_divider u_mant_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .num_m     (a_m_q),
      .den_m     (b_m_q),
      .done      (div_done),
      .quotient  (div_quot),
      .remainder (div_rem)
   );

   assign input_a_ack  = a_ack_q;
   assign input_b_ack  = b_ack_q;
   assign output_z     = out_z_q;
   assign output_z_stb = z_stb_q;
   assign dbg_state    = state_q;

   // Next-state and datapath updates for every sequencing state.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      z_d      = z_q;
      a_m_d    = a_m_q;
      b_m_d    = b_m_q;
      z_m_d    = z_m_q;
      a_e_d    = a_e_q;
      b_e_d    = b_e_q;
      z_e_d    = z_e_q;
      a_s_d    = a_s_q;
      b_s_d    = b_s_q;
      z_s_d    = z_s_q;
      guard_d  = guard_q;
      round_d  = round_q;
      sticky_d = sticky_q;
      a_ack_d  = 1'b0;
      b_ack_d  = 1'b0;
      z_stb_d  = z_stb_q;
      out_z_d  = out_z_q;
      case (state_q)
         GET_A: begin
            if (input_a_stb) begin
               a_d     = input_a;
               a_ack_d = 1'b1;
               state_d = GET_B;
            end
         end
         GET_B: begin
            if (input_b_stb) begin
               b_d     = input_b;
               b_ack_d = 1'b1;
               state_d = UNPACK;
            end
         end
         UNPACK: begin
            a_m_d   = {1'b0, a_q[22:0]};
            b_m_d   = {1'b0, b_q[22:0]};
            a_e_d   = $signed({2'b00, a_q[30:23]}) - BIAS;
            b_e_d   = $signed({2'b00, b_q[30:23]}) - BIAS;
            a_s_d   = a_q[31];
            b_s_d   = b_q[31];
            state_d = SPECIAL_CASES;
         end
         SPECIAL_CASES: begin
            state_d = PUT_Z;
            if (a_nan || b_nan) begin
               z_d = QNAN;
            end else if (a_inf && b_inf) begin
               z_d = QNAN;
            end else if (a_inf) begin
               z_d = signed_inf(sign_ab);
            end else if (b_inf) begin
               z_d = {sign_ab, 31'd0};
            end else if (a_zero && b_zero) begin
               z_d = QNAN;
            end else if (b_zero) begin
               z_d = signed_inf(sign_ab);
            end else if (a_zero) begin
               z_d = {sign_ab, 31'd0};
            end else begin
               // Finite non-zero operands: subnormals take EXP_MIN, normals get the hidden bit.
               state_d = NORMALISE_A;
               if (a_e_q == E_DENORM) a_e_d = EXP_MIN;
               else                   a_m_d[23] = 1'b1;
               if (b_e_q == E_DENORM) b_e_d = EXP_MIN;
               else                   b_m_d[23] = 1'b1;
            end
         end
         NORMALISE_A: begin
            if (a_m_q[23]) begin
               state_d = NORMALISE_B;
            end else begin
               a_m_d = {a_m_q[22:0], 1'b0};
               a_e_d = a_e_q - 10'sd1;
            end
         end
         NORMALISE_B: begin
            if (b_m_q[23]) begin
               state_d = DIVIDE_0;
            end else begin
               b_m_d = {b_m_q[22:0], 1'b0};
               b_e_d = b_e_q - 10'sd1;
            end
         end
         DIVIDE_0: begin
            z_s_d   = sign_ab;
            z_e_d   = a_e_q - b_e_q;
            state_d = DIVIDE_1;
         end
         DIVIDE_1: begin
            state_d = DIVIDE_2;
         end
         DIVIDE_2: begin
            state_d = div_done ? DIVIDE_3 : DIVIDE_1;
         end
         DIVIDE_3: begin
            z_m_d    = div_quot[26:3];
            guard_d  = div_quot[2];
            round_d  = div_quot[1];
            sticky_d = div_quot[0] | (div_rem != 25'd0);
            state_d  = NORMALISE_1;
         end
         NORMALISE_1: begin
            if (!z_m_q[23]) begin
               z_m_d   = {z_m_q[22:0], guard_q};
               guard_d = round_q;
               round_d = 1'b0;
               z_e_d   = z_e_q - 10'sd1;
            end else begin
               state_d = NORMALISE_2;
            end
         end
         NORMALISE_2: begin
            // Denormalise results below the smallest normal exponent.
            if (z_e_q < EXP_MIN) begin
               z_e_d    = z_e_q + 10'sd1;
               z_m_d    = {1'b0, z_m_q[23:1]};
               guard_d  = z_m_q[0];
               round_d  = guard_q;
               sticky_d = sticky_q | round_q;
            end else begin
               state_d = ROUND;
            end
         end
         ROUND: begin
            if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
               z_m_d = z_m_q + 24'd1;
               if (z_m_q == 24'hFFFFFF) z_e_d = z_e_q + 10'sd1;
            end
            state_d = PACK;
         end
         PACK: begin
            z_d[22:0]  = z_m_q[22:0];
            z_d[30:23] = z_e_q[7:0] + 8'd127;
            z_d[31]    = z_s_q;
            if ((z_e_q == EXP_MIN) && !z_m_q[23]) z_d[30:23] = 8'd0;
            if (z_e_q > EXP_MAX) z_d = signed_inf(z_s_q);
            state_d = PUT_Z;
         end
         PUT_Z: begin
            out_z_d = z_q;
            z_stb_d = 1'b1;
            if (z_stb_q && output_z_ack) begin
               z_stb_d = 1'b0;
               state_d = GET_A;
            end
         end
         default: state_d = GET_A;
      endcase
   end

   // State registers; reset overrides any update, including mid-division.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= GET_A;
         a_q      <= '0;
         b_q      <= '0;
         z_q      <= '0;
         a_m_q    <= '0;
         b_m_q    <= '0;
         z_m_q    <= '0;
         a_e_q    <= '0;
         b_e_q    <= '0;
         z_e_q    <= '0;
         a_s_q    <= 1'b0;
         b_s_q    <= 1'b0;
         z_s_q    <= 1'b0;
         guard_q  <= 1'b0;
         round_q  <= 1'b0;
         sticky_q <= 1'b0;
         a_ack_q  <= 1'b0;
         b_ack_q  <= 1'b0;
         z_stb_q  <= 1'b0;
         out_z_q  <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         z_q      <= z_d;
         a_m_q    <= a_m_d;
         b_m_q    <= b_m_d;
         z_m_q    <= z_m_d;
         a_e_q    <= a_e_d;
         b_e_q    <= b_e_d;
         z_e_q    <= z_e_d;
         a_s_q    <= a_s_d;
         b_s_q    <= b_s_d;
         z_s_q    <= z_s_d;
         guard_q  <= guard_d;
         round_q  <= round_d;
         sticky_q <= sticky_d;
         a_ack_q  <= a_ack_d;
         b_ack_q  <= b_ack_d;
         z_stb_q  <= z_stb_d;
         out_z_q  <= out_z_d;
      end
   end

endmodule

// File: tb/tb_fp_single_divider.sv
// Bench for fp_single_divider: directed corner cases, handshake/latency/reset checks and
// random operands compared against an exact-arithmetic IEEE division model.
module tb_fp_single_divider;
   import fp_single_pkg::*;

   localparam logic [31:0] NAN_V = 32'hFFC00000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] input_a = '0;
   logic        input_a_stb = 1'b0;
   logic        input_a_ack;
   logic [31:0] input_b = '0;
   logic        input_b_stb = 1'b0;
   logic        input_b_ack;
   logic [31:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack = 1'b0;
   fp_state_t   dbg_state;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [31:0] exp_q[$];

   fp_single_divider dut (
      .clk          (clk),
      .rst          (rst),
      .input_a      (input_a),
      .input_a_stb  (input_a_stb),
      .input_a_ack  (input_a_ack),
      .input_b      (input_b),
      .input_b_stb  (input_b_stb),
      .input_b_ack  (input_b_ack),
      .output_z     (output_z),
      .output_z_stb (output_z_stb),
      .output_z_ack (output_z_ack),
      .dbg_state    (dbg_state)
   );

   // Clock and edge counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Hang guard.
   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Exact division of the operand values, rounded to nearest even at single precision.
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      logic s, sticky, up, a_inf, b_inf, a_zero, b_zero;
      int ea, eb, p, lead, qe, sh;
      longint unsigned ma, mb, q, r, frac, half, m;
      s      = a[31] ^ b[31];
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      a_zero = (a[30:0] == 31'd0);
      b_zero = (b[30:0] == 31'd0);
      if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0))
         return NAN_V;
      if (a_inf && b_inf) return NAN_V;
      if (a_inf) return {s, 8'hFF, 23'd0};
      if (b_inf) return {s, 31'd0};
      if (a_zero && b_zero) return NAN_V;
      if (b_zero) return {s, 8'hFF, 23'd0};
      if (a_zero) return {s, 31'd0};
      // value = significand * 2^exponent
      if (a[30:23] == 8'd0) begin ma = 64'(a[22:0]); ea = -149; end
      else begin ma = 64'({1'b1, a[22:0]}); ea = int'(a[30:23]) - 150; end
      if (b[30:23] == 8'd0) begin mb = 64'(b[22:0]); eb = -149; end
      else begin mb = 64'({1'b1, b[22:0]}); eb = int'(b[30:23]) - 150; end
      while (ma < 64'h800000) begin ma = ma * 2; ea--; end
      while (mb < 64'h800000) begin mb = mb * 2; eb--; end
      q      = (ma << 40) / mb;
      r      = (ma << 40) % mb;
      sticky = (r != 0);
      p      = (q >= (64'd1 << 40)) ? 40 : 39;
      lead   = p + ea - eb - 40;
      qe     = (lead - 23 > -149) ? lead - 23 : -149;
      sh     = qe - (ea - eb - 40);
      if (sh >= 42) begin
         m = 0;
      end else begin
         m    = q >> sh;
         frac = q & ((64'd1 << sh) - 1);
         half = 64'd1 << (sh - 1);
         up   = (frac > half) || (frac == half && (sticky || m[0]));
         if (up) m = m + 1;
         if (m == (64'd1 << 24)) begin m = 64'd1 << 23; qe++; end
      end
      if (m >= (64'd1 << 23)) begin
         if (qe + 150 >= 255) return {s, 8'hFF, 23'd0};
         return {s, 8'(qe + 150), m[22:0]};
      end
      return {s, 8'd0, m[22:0]};
   endfunction

   function automatic logic [31:0] rand_fp();
      int          sel;
      logic [7:0]  e;
      logic [22:0] m;
      sel = $urandom_range(0, 19);
      m   = 23'($urandom);
      if (sel == 0) begin e = 8'h00; m = m >> $urandom_range(0, 22); end
      else if (sel == 1) begin e = 8'h00; m = '0; end
      else if (sel == 2) e = 8'hFF;
      else if (sel == 3) begin e = 8'hFF; m = '0; end
      else if (sel < 12) e = 8'($urandom_range(100, 154));
      else e = 8'($urandom_range(1, 254));
      return {1'($urandom), e, m};
   endfunction

   // Driver: present a then b, wait for each acknowledge, queue the expected result.
   task automatic send_pair(input logic [31:0] a, input logic [31:0] b, output int acc_cyc);
      int n;
      @(negedge clk);
      input_a     = a;
      input_a_stb = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!input_a_ack && n < 200);
      input_a_stb = 1'b0;
      check32("a_ack", {31'd0, input_a_ack}, 32'd1);
      input_b     = b;
      input_b_stb = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!input_b_ack && n < 200);
      input_b_stb = 1'b0;
      check32("b_ack", {31'd0, input_b_ack}, 32'd1);
      check32("a_ack_pulse", {31'd0, input_a_ack}, 32'd0);
      acc_cyc = cyc;
      exp_q.push_back(ref_div(a, b));
   endtask

   // Consumer: wait for the result, optionally stall, then acknowledge.
   task automatic get_result(input string tag, input int hold, output int stb_cyc);
      int          n;
      logic [31:0] z0, e;
      n = 0;
      while (!output_z_stb && n < 1000) begin @(negedge clk); n++; end
      check32({tag, "_stb"}, {31'd0, output_z_stb}, 32'd1);
      stb_cyc = cyc;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
      check32(tag, output_z, e);
      z0 = output_z;
      repeat (hold) begin
         @(negedge clk);
         check32("hold_stb", {31'd0, output_z_stb}, 32'd1);
         check32("hold_z", output_z, z0);
      end
      output_z_ack = 1'b1;
      @(negedge clk);
      output_z_ack = 1'b0;
      check32("stb_drop", {31'd0, output_z_stb}, 32'd0);
      check32("z_keep", output_z, z0);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input int hold);
      int acc, sc;
      send_pair(a, b, acc);
      get_result(tag, hold, sc);
   endtask

   // Directed sequence followed by random operands.
   initial begin
      int acc, sc, n;

      // reset state
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check32("rst_a_ack", {31'd0, input_a_ack}, 32'd0);
      check32("rst_b_ack", {31'd0, input_b_ack}, 32'd0);
      check32("rst_stb", {31'd0, output_z_stb}, 32'd0);
      check32("rst_z", output_z, 32'd0);
      check32("rst_state", 32'(dbg_state), 32'(GET_A));

      // 6/3 with latency from b acceptance
      send_pair(32'h40C00000, 32'h40400000, acc);
      get_result("div_6_3", 0, sc);
      check32("latency", 32'(sc - acc), 32'd111);

      run_op("div_1_3", 32'h3F800000, 32'h40400000, 5);
      run_op("div_by_zero", 32'h3F800000, 32'h00000000, 0);
      run_op("zero_by_zero", 32'h00000000, 32'h80000000, 1);
      run_op("neg_by_inf", 32'hC1000000, 32'h7F800000, 0);
      run_op("overflow", 32'h7F7FFFFF, 32'h00800000, 0);
      run_op("subnormal", 32'h00800000, 32'h40000000, 0);
      run_op("tie_even_up", 32'h00000003, 32'h40000000, 0);
      run_op("tie_even_down", 32'h00000001, 32'h40000000, 0);
      run_op("nan_in", 32'h7FC00001, 32'h3F800000, 0);
      run_op("inf_by_inf", 32'hFF800000, 32'h7F800000, 0);

      for (int i = 0; i < 40; i++) begin
         run_op("random", rand_fp(), rand_fp(), int'($urandom_range(0, 2)));
      end

      // reset in the middle of the mantissa division
      run_op("pre_rst", 32'h3F800000, 32'h40400000, 0);
      send_pair(32'h40C00000, 32'h40400000, acc);
      void'(exp_q.pop_back());
      n = 0;
      while (dbg_state != DIVIDE_1 && n < 100) begin @(negedge clk); n++; end
      check32("reach_div1", 32'(dbg_state), 32'(DIVIDE_1));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check32("mid_rst_a_ack", {31'd0, input_a_ack}, 32'd0);
      check32("mid_rst_b_ack", {31'd0, input_b_ack}, 32'd0);
      check32("mid_rst_stb", {31'd0, output_z_stb}, 32'd0);
      check32("mid_rst_z", output_z, 32'd0);
      check32("mid_rst_state", 32'(dbg_state), 32'(GET_A));
      run_op("after_rst", 32'h40C00000, 32'h40400000, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_single_divider.md
FP_SINGLE_DIVIDER -- requirements
Module: fp_single_divider

Interface
REQ-001 SHALL have parameter QNAN, default 32'hFFC00000, canonical NaN returned on invalid operations.
REQ-002 SHALL have clk input 1: clock; all state changes on rising edge.
REQ-003 SHALL have rst input 1: reset, synchronous, active-high.
REQ-004 SHALL have input_a input 32: IEEE-754 single dividend.
REQ-005 SHALL have input_a_stb input 1: input_a valid.
REQ-006 SHALL have input_a_ack output 1: input_a accepted.
REQ-007 SHALL have input_b input 32: IEEE-754 single divisor.
REQ-008 SHALL have input_b_stb input 1: input_b valid.
REQ-009 SHALL have input_b_ack output 1: input_b accepted.
REQ-010 SHALL have output_z output 32: quotient a/b, IEEE-754 single.
REQ-011 SHALL have output_z_stb output 1: output_z valid.
REQ-012 SHALL have output_z_ack input 1: consumer accepted output_z.

Function
REQ-013 SHALL run FSM get_a, get_b, unpack, special_cases, normalise_a, normalise_b, divide_0, divide_1, divide_2, divide_3, normalise_1, normalise_2, round, pack, put_z.
REQ-014 SHALL in get_a capture input_a on the edge where input_a_stb=1, pulse input_a_ack high for exactly the following cycle, then go to get_b; get_b does the same for b with input_b_ack, then goes to unpack.
REQ-015 SHALL unpack: mantissa = bits[22:0], exponent = bits[30:23]-127 in a 10-bit signed field, sign = bit 31.
REQ-016 SHALL apply special cases in priority order, then go to put_z:
- a or b NaN -> QNAN
- a inf and b inf -> QNAN
- a inf -> inf, sign a_s^b_s
- b inf -> zero, sign a_s^b_s
- b zero and a zero -> QNAN
- b zero -> inf, sign a_s^b_s
- a zero -> zero, sign a_s^b_s
REQ-017 SHALL otherwise handle each operand as follows: subnormal -> exponent -126; normal -> hidden bit 23 set. Normalise_a/normalise_b SHALL then shift left one bit per cycle, decrementing the exponent, until bit 23 is set.
REQ-018 SHALL in divide_0 set:
- z_s = a_s^b_s
- z_e = a_e-b_e
- 51-bit dividend = a_m<<27
- divisor = b_m
- quotient, remainder and count cleared
REQ-019 SHALL perform restoring division, one bit per divide_1/divide_2 pair:
- divide_1 shifts the dividend MSB into the remainder and shifts the quotient left.
- divide_2 subtracts the divisor and sets quotient[0] when remainder>=divisor.
- 50 iterations in total (count 0..49), then divide_3.
REQ-020 SHALL in divide_3 set:
- z_m = quotient[26:3]
- guard = quotient[2]
- round_bit = quotient[1]
- sticky = quotient[0] | (remainder!=0)
REQ-021 SHALL in normalise_1 shift z_m left one bit per cycle while z_m[23]=0, shifting guard into bit 0, round_bit into guard and 0 into round_bit, and decrementing z_e.
REQ-022 SHALL in normalise_2, while z_e<-126, shift right one bit per cycle and increment z_e, with round_bit OR'd into sticky.
REQ-023 SHALL round to nearest even: increment z_m when guard & (round_bit|sticky|z_m[0]); when z_m was 24'hFFFFFF, also increment z_e.
REQ-024 SHALL pack:
- biased exponent z_e+127
- exponent field 0 when z_e=-126 and z_m[23]=0 (subnormal)
- z_e>127 -> signed infinity
REQ-025 SHALL in put_z drive output_z and output_z_stb=1, and hold both stable until an edge with output_z_stb=1 and output_z_ack=1. After that edge, output_z_stb SHALL be 0 and the FSM SHALL be in get_a.
REQ-026 SHALL assert output_z_stb 111 clock edges after the edge accepting b when neither operand nor quotient needs a normalisation shift.
REQ-027 SHALL ignore input strobes outside get_a/get_b; output_z SHALL hold its last value while output_z_stb=0.

Reset
REQ-028 SHALL, with rst=1 at an edge, force state=get_a, input_a_ack=0, input_b_ack=0, output_z_stb=0, output_z=0, overriding any FSM update that cycle, including mid-division.
REQ-029 SHALL accept a fresh operand pair normally on the first edge after rst falls.

Structure
REQ-030 SHALL take the following from shared package fp_single_pkg, shared with the multiplier: state encoding, BIAS=127, EXP_MIN=-126, EXP_MAX=127, QNAN and POS_INF constants.
REQ-031 SHALL contain one sub-module, fp_mant_divider: a 50-iteration restoring divider with start/done, preserving the REQ-026 latency.

Verification
REQ-032 SHALL cover: 40C00000 / 40400000 (6/3) -> 40000000, stb exactly 111 edges after b accepted.
REQ-033 SHALL cover: 3F800000 / 40400000 (1/3) -> 3EAAAAAB (round-up path).
REQ-034 SHALL cover:
- 3F800000 / 00000000 -> 7F800000
- 00000000 / 80000000 -> FFC00000
- C1000000 / 7F800000 -> 80000000
REQ-035 SHALL cover: 7F7FFFFF / 00800000 -> 7F800000 (overflow); 00800000 / 40000000 -> 00400000 (subnormal result).
REQ-036 SHALL cover: output_z_ack held low 5 cycles -> output_z_stb and output_z stable; ack=1 -> stb=0 next cycle and the next operand accepted.
REQ-037 SHALL cover: rst pulsed during divide_1 -> all outputs 0 next cycle; subsequent 40C00000/40400000 -> 40000000.
